t02_ram_responder: RTL and testbench

T02_RAM_RESPONDER -- requirements
Module: t02_ram_responder

---
 rtl/t02_ram_responder.sv | 113 +++++++++++
 tb/tb_t02_ram_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/t02_ram_responder.sv
// rtl/t02_ram_responder.sv - fixed-latency word RAM responder behind an IDLE/BUSY/DONE handshake.
// Optional macro T02_RAM_RESP_OOR_EN: flags out-of-range addresses on err_o instead of wrapping.
module t02_ram_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
`ifdef T02_RAM_RESP_OOR_EN
  ,
  output logic        err_o
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_busy;
  logic          w_start;
  logic          w_finish;
  logic          w_oor;
  logic [AW-1:0] w_index;
  logic          w_unused_bits;

  assign w_req    = Ren | Wen;
  assign w_start  = (r_state == S_IDLE) && w_req;
  assign w_finish = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_index  = r_addr[2 +: AW];
  assign w_unused_bits = ^{r_addr[1:0], r_addr[31:2+AW]};

`ifdef T02_RAM_RESP_OOR_EN
  assign w_oor = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = w_req;
        if (w_req) w_next = S_BUSY;
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Gated by reset so an aborted access drops busy_o at once, even with a request still held.
  assign busy_o = w_busy & nRST;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      ramload <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_addr <= ramaddr;
        r_data <= ramstore;
        r_rd   <= Ren;
        r_wr   <= Wen;
        r_cnt  <= 4'(LATENCY - 1);
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // On a combined read/write this returns the pre-write word.
      if (w_finish && r_rd) ramload <= w_oor ? 32'hDEADBEEF : r_mem[w_index];
    end
  end

`ifdef T02_RAM_RESP_OOR_EN
  logic r_err;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_err <= 1'b0;
    else       r_err <= w_finish & w_oor;
  end
  assign err_o = r_err;
`endif

  // Array is deliberately outside the reset domain; reset forces IDLE so no write can complete.
  always_ff @(posedge CLK) begin
    if (w_finish && r_wr && !w_oor) r_mem[w_index] <= r_data;
  end

endmodule

// File: tb/tb_t02_ram_responder.sv
// tb/tb_t02_ram_responder.sv - directed plus randomized bench for t02_ram_responder.
module tb_t02_ram_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        Ren;
  logic        Wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        busy_o;
  logic        err_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_load;
  logic [31:0] prior_30;

  always #5 CLK = ~CLK;

  t02_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .Ren      (Ren),
    .Wen      (Wen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .busy_o   (busy_o)
`ifdef T02_RAM_RESP_OOR_EN
    ,
    .err_o    (err_o)
`endif
  );

`ifndef T02_RAM_RESP_OOR_EN
  assign err_o = 1'b0;
`endif

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_oor(input logic [31:0] a);
`ifdef T02_RAM_RESP_OOR_EN
    return (a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // One complete access: busy expected for cycles 0..LAT, completion in cycle LAT+1.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold, input bit scramble);
    bit is_oor;
    int i;
    @(posedge CLK); #1;
    Ren = rd; Wen = wr; ramaddr = addr; ramstore = data;
    is_oor = addr_oor(addr);
    i = addr_idx(addr);
    if (rd) exp_load = is_oor ? 32'hDEADBEEF : model_mem[i];
    if (wr && !is_oor) model_mem[i] = data;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge CLK);
      check32({tag, ".busy"}, {31'b0, busy_o}, (k <= LAT) ? 32'd1 : 32'd0);
`ifdef T02_RAM_RESP_OOR_EN
      check32({tag, ".err"}, {31'b0, err_o}, ((k == LAT + 1) && is_oor) ? 32'd1 : 32'd0);
`endif
      if (k == LAT + 1) check32({tag, ".ramload"}, ramload, exp_load);
      if (scramble && k == 1) begin
        ramaddr = $urandom; ramstore = $urandom;
      end
    end
    if (!hold) begin
      @(posedge CLK); #1;
      Ren = 1'b0; Wen = 1'b0;
      @(negedge CLK);
      check32({tag, ".idle_busy"}, {31'b0, busy_o}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit rd, wr;
    logic [31:0] a;
    nRST = 1'b0; Ren = 1'b0; Wen = 1'b0; ramaddr = 32'h0; ramstore = 32'h0;
    exp_load = 32'h0;
    #1;
    check32("reset.ramload", ramload, 32'h0);
    check32("reset.busy", {31'b0, busy_o}, 32'd0);
`ifdef T02_RAM_RESP_OOR_EN
    check32("reset.err", {31'b0, err_o}, 32'd0);
`endif
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    for (int n = 0; n < DEPTH; n++) access("init", 1'b0, 1'b1, 32'(n * 4), $urandom, 1'b0, 1'b0);
    check32("init.ramload_kept", ramload, 32'h0);

    access("wr10", 1'b0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0, 1'b0);
    access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    check32("rd10.value", ramload, 32'hA5A5_0001);

    access("b2b_first", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    access("b2b_second", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    access("wr20", 1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b0, 1'b0);
    access("rw20", 1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b0, 1'b0);
    check32("rw20.preword", ramload, 32'h1111_1111);
    access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    check32("rd20.newword", ramload, 32'h2222_2222);

    access("scr_rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    access("scr_wr10", 1'b0, 1'b1, 32'h10, 32'h5A5A_7777, 1'b0, 1'b1);
    access("scr_chk10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    access("rd400", 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
    access("wr400", 1'b0, 1'b1, 32'h400, 32'hCAFE_0400, 1'b0, 1'b0);
    access("rd000", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    @(negedge CLK); #1;
    Wen = 1'b1; ramaddr = 32'h10; ramstore = 32'hBAD0_BAD0;
    #2 Wen = 1'b0;
    @(negedge CLK);
    check32("glitch.busy", {31'b0, busy_o}, 32'd0);
    access("glitch.rd10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

    prior_30 = model_mem[12];
    @(posedge CLK); #1;
    Wen = 1'b1; ramaddr = 32'h30; ramstore = 32'hFFFF_FFFF;
    @(negedge CLK);
    check32("rst_mid.busy_c0", {31'b0, busy_o}, 32'd1);
    @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    check32("rst_mid.busy", {31'b0, busy_o}, 32'd0);
    check32("rst_mid.ramload", ramload, 32'h0);
    Wen = 1'b0;
    exp_load = 32'h0;
    @(posedge CLK); #1 nRST = 1'b1;
    access("rst_mid.rd30", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0);
    check32("rst_mid.prior", ramload, prior_30);

    for (int n = 0; n < 150; n++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 32'hFFF);
      else a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      access("rand", rd, wr, a, $urandom, (n != 149) && ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
